// File: rtl/cpu_pkg.sv
// cpu_pkg: shared datapath word width and word type for the CPU arithmetic blocks.
package cpu_pkg;
    localparam int WORD_W = 16;
    typedef logic [WORD_W-1:0] word_t;
endpackage

// File: rtl/add16_registered_if.sv
// add16_registered_if: operand/result bundle between the datapath and the registered adder.
interface add16_registered_if;
    import cpu_pkg::*;
    logic  in_valid;
    word_t a;
    word_t b;
    word_t out;
    logic  cout;
    logic  out_valid;
    modport master (output in_valid, a, b, input out, cout, out_valid);
    modport slave (input in_valid, a, b, output out, cout, out_valid);
endinterface

// File: rtl/full_adder.sv
// full_adder: single-bit full adder cell used to build the ripple-carry chain.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic carry
);
    assign sum   = a ^ b ^ cin;
    assign carry = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/add16_registered.sv
// add16_registered: ripple-carry unsigned adder with sum, carry and valid registered on clk.
module add16_registered
    import cpu_pkg::*;
#(
    parameter int WIDTH = WORD_W
) (
    input  logic              clk,
    input  logic              rst_n,
    add16_registered_if.slave bus
);
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH:0]   w_carry;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_valid;

    assign w_carry[0] = 1'b0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        full_adder u_fa (
            .a     (bus.a[i]),
            .b     (bus.b[i]),
            .cin   (w_carry[i]),
            .sum   (w_sum[i]),
            .carry (w_carry[i+1])
        );
    end

    // Capture only on in_valid so idle-cycle operands (possibly X) never reach the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_sum  <= w_sum;
                r_cout <= w_carry[WIDTH];
            end
        end
    end

    assign bus.out       = r_sum;
    assign bus.cout      = r_cout;
    assign bus.out_valid = r_valid;
endmodule

// File: tb/tb_add16_registered.sv
// tb_add16_registered: directed vector table, corner sequences and randomized model check.
module tb_add16_registered;
    logic clk;
    logic rst_n;
    int   passed;
    int   total;

    add16_registered_if bus ();

    add16_registered dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] s;
        logic        c;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic check_all(input string name, input logic [15:0] s, input logic c, input logic v);
        check({name, " out"}, {16'h0, bus.out}, {16'h0, s});
        check({name, " cout"}, {31'h0, bus.cout}, {31'h0, c});
        check({name, " out_valid"}, {31'h0, bus.out_valid}, {31'h0, v});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [16:0] m_res;
    logic        m_valid;
    logic        iv;
    logic [15:0] ra;
    logic [15:0] rb;

    initial begin
        passed = 0;
        total  = 0;
        vecs[0] = '{16'h0000, 16'h0000, 16'h0000, 1'b0};
        vecs[1] = '{16'h0000, 16'hFFFF, 16'hFFFF, 1'b0};
        vecs[2] = '{16'hAAAA, 16'h5555, 16'hFFFF, 1'b0};
        vecs[3] = '{16'hFFFF, 16'h0001, 16'h0000, 1'b1};
        vecs[4] = '{16'h33C3, 16'h0FF0, 16'h43B3, 1'b0};
        vecs[5] = '{16'h0948, 16'h9876, 16'hA1BE, 1'b0};
        vecs[6] = '{16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b1};

        // Reset held with a live operation on the inputs.
        rst_n        = 1'b0;
        bus.in_valid = 1'b1;
        bus.a        = 16'hFFFF;
        bus.b        = 16'hFFFF;
        #1;
        check_all("reset t1", 16'h0000, 1'b0, 1'b0);
        tick();
        check_all("reset edge1", 16'h0000, 1'b0, 1'b0);
        tick();
        check_all("reset edge2", 16'h0000, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick();
        check_all("first capture", 16'hFFFE, 1'b1, 1'b1);

        // Directed vectors streamed back-to-back.
        for (int i = 0; i < 7; i++) begin
            bus.a        = vecs[i].a;
            bus.b        = vecs[i].b;
            bus.in_valid = 1'b1;
            tick();
            check_all($sformatf("vec%0d", i), vecs[i].s, vecs[i].c, 1'b1);
        end

        // Hold: idle cycle with new operands must not disturb FFFE,c1.
        bus.in_valid = 1'b0;
        bus.a        = 16'h1234;
        bus.b        = 16'h1111;
        tick();
        check_all("hold", 16'hFFFE, 1'b1, 1'b0);
        bus.a = 16'hx;
        bus.b = 16'hx;
        tick();
        check_all("hold x", 16'hFFFE, 1'b1, 1'b0);

        // Mid-stream reset between edges discards the in-flight result.
        bus.in_valid = 1'b1;
        bus.a        = 16'h1234;
        bus.b        = 16'h1111;
        tick();
        check_all("pre reset", 16'h2345, 1'b0, 1'b1);
        bus.a = 16'h8000;
        bus.b = 16'h8000;
        #2;
        rst_n = 1'b0;
        #1;
        check_all("async reset", 16'h0000, 1'b0, 1'b0);
        tick();
        check_all("reset hold", 16'h0000, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick();
        check_all("after reset", 16'h0000, 1'b1, 1'b1);

        // Randomized traffic against an arithmetic reference.
        m_res   = 17'h10000;
        m_valid = 1'b1;
        for (int k = 0; k < 300; k++) begin
            iv           = ($urandom_range(0, 3) != 0);
            ra           = 16'($urandom);
            rb           = 16'($urandom);
            bus.in_valid = iv;
            bus.a        = ra;
            bus.b        = rb;
            if (iv) m_res = {1'b0, ra} + {1'b0, rb};
            m_valid = iv;
            tick();
            check_all($sformatf("rand%0d", k), m_res[15:0], m_res[16], m_valid);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
